// File: rtl/axil2wb_arbiter.sv
// axil2wb_arbiter: shares one pipelined Wishbone master port between the
// AXI-lite read bridge (port A) and the AXI-lite write bridge (port B).
// The bus is granted round-robin and stays with one port for its whole cyc.
// A watchdog aborts a cycle that never gets an ack or err, so neither AXI
// channel can deadlock.
//
// state    | meaning
// ---------+--------------------------------------------------------
// OWN_NONE | bus idle, nobody granted
// OWN_A    | port A (read bridge) owns the bus until it drops cyc
// OWN_B    | port B (write bridge) owns the bus until it drops cyc
module axil2wb_arbiter #(
  parameter int AW        = 26,
  parameter int DW        = 32,
  parameter int LGTIMEOUT = 8
) (
  input  logic            i_clk,
  input  logic            w_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t owner, owner_next;
  logic   r_last, last_next;   // 0 = A was granted last, 1 = B
  logic   owner_cyc;
  logic   rearb;
  logic   r_timeout;           // cycle aborted, held until the owner drops cyc
  logic   r_tpulse;            // one-cycle err pulse announcing the abort

  // Grant register; reset favours A on the first tie by marking B as last.
  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      owner  <= OWN_NONE;
      r_last <= 1'b1;
    end else begin
      owner  <= owner_next;
      r_last <= last_next;
    end
  end

  // Round-robin arbitration, only while the bus is free or its owner left.
  always_comb begin
    owner_next = owner;
    last_next  = r_last;
    owner_cyc  = 1'b0;
    case (owner)
      OWN_A:   owner_cyc = i_a_cyc;
      OWN_B:   owner_cyc = i_b_cyc;
      default: owner_cyc = 1'b0;
    endcase
    rearb = (owner == OWN_NONE) || !owner_cyc;
    if (rearb) begin
      if (i_a_cyc && (!i_b_cyc || r_last)) begin
        owner_next = OWN_A;
        last_next  = 1'b0;
      end else if (i_b_cyc) begin
        owner_next = OWN_B;
        last_next  = 1'b1;
      end else begin
        owner_next = OWN_NONE;
      end
    end
  end

  // Forward mux from the owner and return routing back to it.
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_wb_sel  = '0;
    o_a_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_stall = 1'b1;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    o_rdata   = i_wb_data;
    case (owner)
      OWN_A: begin
        o_wb_cyc  = i_a_cyc & !r_timeout;
        o_wb_stb  = i_a_cyc & i_a_stb & !r_timeout;
        o_wb_we   = i_a_we;
        o_wb_addr = i_a_addr;
        o_wb_data = i_a_data;
        o_wb_sel  = i_a_sel;
        o_a_stall = i_wb_stall;
        o_a_ack   = i_wb_ack & o_wb_cyc;
        o_a_err   = (i_wb_err & o_wb_cyc) | r_tpulse;
      end
      OWN_B: begin
        o_wb_cyc  = i_b_cyc & !r_timeout;
        o_wb_stb  = i_b_cyc & i_b_stb & !r_timeout;
        o_wb_we   = i_b_we;
        o_wb_addr = i_b_addr;
        o_wb_data = i_b_data;
        o_wb_sel  = i_b_sel;
        o_b_stall = i_wb_stall;
        o_b_ack   = i_wb_ack & o_wb_cyc;
        o_b_err   = (i_wb_err & o_wb_cyc) | r_tpulse;
      end
      default: ;
    endcase
  end

  generate
    if (LGTIMEOUT > 0) begin : g_wdog
      logic [LGTIMEOUT-1:0] r_count;

      // Watchdog: count response-less bus cycles; an ack/err on the terminal
      // count wins over the timeout.
      always_ff @(posedge i_clk) begin
        if (w_reset) begin
          r_count   <= '0;
          r_timeout <= 1'b0;
          r_tpulse  <= 1'b0;
        end else begin
          r_tpulse <= 1'b0;
          if (!o_wb_cyc || i_wb_ack || i_wb_err)
            r_count <= '0;
          else
            r_count <= r_count + LGTIMEOUT'(1);
          if (rearb)
            r_timeout <= 1'b0;
          else if (o_wb_cyc && !i_wb_ack && !i_wb_err && (&r_count)) begin
            r_timeout <= 1'b1;
            r_tpulse  <= 1'b1;
          end
        end
      end
    end else begin : g_no_wdog
      assign r_timeout = 1'b0;
      assign r_tpulse  = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_axil2wb_arbiter.sv
// tb_axil2wb_arbiter: directed stimulus for the two-port Wishbone arbiter.
// Expected port responses go into a queue as stimulus is issued; a monitor
// pops and compares whenever a port shows ack or err.
module tb_axil2wb_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;

  logic            i_clk = 1'b0;
  logic            w_reset;
  logic            a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_data, b_data;
  logic [DW/8-1:0] a_sel, b_sel;
  logic            o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
  logic [DW-1:0]   o_rdata;
  logic            o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            wb_ack, wb_stall, wb_err;
  logic [DW-1:0]   wb_data;

  typedef struct {
    logic          port;   // 0 = A, 1 = B
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  axil2wb_arbiter #(.AW(AW), .DW(DW), .LGTIMEOUT(4)) dut (
    .i_clk(i_clk), .w_reset(w_reset),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_data), .i_a_sel(a_sel),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_data), .i_b_sel(b_sel),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err),
    .o_rdata(o_rdata),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
    .i_wb_data(wb_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_resp(input logic port, input logic err, input logic [DW-1:0] data);
    resp_t r;
    r.port = port;
    r.err  = err;
    r.data = data;
    sb.push_back(r);
  endtask

  // Response monitor: every ack/err seen on a port must match the queue head.
  always @(negedge i_clk) begin
    resp_t e;
    if (o_a_ack || o_a_err || o_b_ack || o_b_err) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got a_ack=%0b a_err=%0b b_ack=%0b b_err=%0b, want none",
                 o_a_ack, o_a_err, o_b_ack, o_b_err);
      end else begin
        e = sb.pop_front();
        chk("resp_port", {62'd0, o_b_ack | o_b_err, o_a_ack | o_a_err}, e.port ? 64'd2 : 64'd1);
        chk("resp_err", {63'd0, o_a_err | o_b_err}, {63'd0, e.err});
        if (!e.err) chk("resp_data", {32'd0, o_rdata}, {32'd0, e.data});
      end
    end
  end

  initial begin
    int n;
    w_reset = 1'b1;
    a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_data = 32'hA0A0A0A0; a_sel = 4'hF;
    b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_data = 32'hB0B0B0B0; b_sel = 4'h3;
    wb_ack = 0; wb_stall = 0; wb_err = 0; wb_data = '0;
    tick();
    tick();
    chk("rst_cyc", {63'd0, o_wb_cyc}, 64'd0);
    chk("rst_stb", {63'd0, o_wb_stb}, 64'd0);
    chk("rst_addr", {38'd0, o_wb_addr}, 64'd0);
    chk("rst_stalls", {62'd0, o_a_stall, o_b_stall}, 64'd3);
    chk("rst_resps", {60'd0, o_a_ack, o_a_err, o_b_ack, o_b_err}, 64'd0);
    w_reset = 1'b0;
    tick();

    // A read on an idle bus
    a_cyc = 1; a_stb = 1; a_we = 0; a_addr = 26'h10;
    chk("a_not_yet", {63'd0, o_wb_cyc}, 64'd0);
    tick();
    chk("a_grant_cyc", {63'd0, o_wb_cyc}, 64'd1);
    chk("a_grant_addr", {38'd0, o_wb_addr}, 64'h10);
    chk("a_grant_bstall", {63'd0, o_b_stall}, 64'd1);
    a_stb = 0; wb_ack = 1; wb_data = 32'hDEADBEEF;
    expect_resp(1'b0, 1'b0, 32'hDEADBEEF);
    tick();
    wb_ack = 0; a_cyc = 0;
    tick();
    tick();
    // late ack on an idle bus goes nowhere
    wb_ack = 1;
    #1;
    chk("late_ack", {62'd0, o_a_ack, o_b_ack}, 64'd0);
    tick();
    wb_ack = 0;

    // Tie after reset: A first, then B, then the next tie goes to A
    w_reset = 1;
    tick();
    w_reset = 0;
    a_cyc = 1; a_stb = 1; a_addr = 26'h20;
    b_cyc = 1; b_stb = 1; b_we = 1; b_addr = 26'h30;
    tick();
    chk("tie1_addr", {38'd0, o_wb_addr}, 64'h20);
    chk("tie1_bstall", {63'd0, o_b_stall}, 64'd1);
    a_stb = 0; wb_ack = 1; wb_data = 32'h11111111;
    expect_resp(1'b0, 1'b0, 32'h11111111);
    tick();
    wb_ack = 0; a_cyc = 0;
    #1;
    chk("a_drop_cyc", {63'd0, o_wb_cyc}, 64'd0);
    tick();
    chk("hand_b_addr", {38'd0, o_wb_addr}, 64'h30);
    chk("hand_b_we", {63'd0, o_wb_we}, 64'd1);
    a_cyc = 1; a_stb = 1;
    tick();
    chk("b_held_addr", {38'd0, o_wb_addr}, 64'h30);
    chk("b_held_astall", {63'd0, o_a_stall}, 64'd1);
    b_stb = 0; wb_ack = 1; wb_data = 32'h22222222;
    expect_resp(1'b1, 1'b0, 32'h22222222);
    tick();
    wb_ack = 0; a_cyc = 0; b_cyc = 0;
    tick();
    chk("idle_cyc", {63'd0, o_wb_cyc}, 64'd0);
    a_cyc = 1; b_cyc = 1; b_stb = 1;
    tick();
    chk("tie2_addr", {38'd0, o_wb_addr}, 64'h20);
    a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0;
    tick();
    tick();

    // B pipelined write burst with stall, A waiting
    b_cyc = 1; b_stb = 1; b_we = 1; b_addr = 26'h40; b_data = 32'hCAFE0001; b_sel = 4'h3;
    tick();
    a_cyc = 1; a_stb = 1; a_addr = 26'h20; wb_stall = 1;
    #1;
    chk("bst_stall1", {62'd0, o_b_stall, o_a_stall}, 64'd3);
    chk("bst_addr1", {38'd0, o_wb_addr}, 64'h40);
    chk("bst_wdata", {32'd0, o_wb_data}, 64'hCAFE0001);
    chk("bst_sel", {60'd0, o_wb_sel}, 64'h3);
    tick();
    chk("bst_stall2", {63'd0, o_b_stall}, 64'd1);
    chk("bst_addr2", {38'd0, o_wb_addr}, 64'h40);
    wb_stall = 0;
    #1;
    chk("bst_unstall", {62'd0, o_b_stall, o_a_stall}, 64'd1);
    tick();
    b_addr = 26'h41; wb_ack = 1; wb_data = 32'h000000A1;
    expect_resp(1'b1, 1'b0, 32'h000000A1);
    tick();
    b_addr = 26'h42; wb_data = 32'h000000A2;
    expect_resp(1'b1, 1'b0, 32'h000000A2);
    tick();
    b_stb = 0; wb_data = 32'h000000A3;
    expect_resp(1'b1, 1'b0, 32'h000000A3);
    chk("bst_still_b", {38'd0, o_wb_addr}, 64'h42);
    tick();
    wb_ack = 0; b_cyc = 0;
    tick();
    chk("a_after_b", {38'd0, o_wb_addr}, 64'h20);
    chk("a_after_b_cyc", {63'd0, o_wb_cyc}, 64'd1);

    // Watchdog: slave never answers A, B pending
    b_cyc = 1; b_stb = 1; b_we = 1; b_addr = 26'h50;
    expect_resp(1'b0, 1'b1, 32'h0);
    n = 0;
    while (!o_a_err && n < 30) begin
      tick();
      n++;
    end
    chk("wdog_fired", {63'd0, o_a_err}, 64'd1);
    chk("wdog_delay_ok", {63'd0, (n >= 15 && n <= 16)}, 64'd1);
    chk("wdog_cyc_off", {62'd0, o_wb_cyc, o_wb_stb}, 64'd0);
    chk("wdog_berr", {63'd0, o_b_err}, 64'd0);
    tick();
    chk("wdog_pulse_end", {63'd0, o_a_err}, 64'd0);
    chk("wdog_cyc_held", {63'd0, o_wb_cyc}, 64'd0);
    a_cyc = 0; a_stb = 0;
    tick();
    chk("wdog_b_grant", {38'd0, o_wb_addr}, 64'h50);
    chk("wdog_b_cyc", {63'd0, o_wb_cyc}, 64'd1);

    // Slave error during a B write, A waiting
    a_cyc = 1; a_stb = 1;
    tick();
    b_stb = 0; wb_err = 1;
    expect_resp(1'b1, 1'b1, 32'h0);
    #1;
    chk("berr_a_quiet", {63'd0, o_a_err}, 64'd0);
    tick();
    wb_err = 0;
    #1;
    chk("berr_held", {38'd0, o_wb_addr}, 64'h50);
    chk("berr_held_cyc", {63'd0, o_wb_cyc}, 64'd1);
    b_cyc = 0;
    tick();
    chk("berr_a_grant", {38'd0, o_wb_addr}, 64'h20);

    // Reset while A owns the bus mid-transfer
    tick();
    chk("mid_a_cyc", {63'd0, o_wb_cyc}, 64'd1);
    w_reset = 1;
    tick();
    chk("mid_rst_cyc", {63'd0, o_wb_cyc}, 64'd0);
    chk("mid_rst_stalls", {62'd0, o_a_stall, o_b_stall}, 64'd3);
    chk("mid_rst_addr", {38'd0, o_wb_addr}, 64'd0);
    a_cyc = 0; a_stb = 0;
    tick();
    w_reset = 0;
    tick();
    tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
